sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO that replaces the fixed 8-deep buffer used between RSA array stages and the EKF datapath.
- Any depth (non-power-of-2 allowed) and any data width.
- Occupancy level output, programmable almost-full/almost-empty flags, synchronous flush, sticky overflow/underflow error flags, read-valid qualifier.
- Sits between producer/consumer stages in a single clock domain.

Parameters:
DW, 16, data width in bits
DEPTH, 8, number of entries, >=2, need not be a power of 2
AW, $clog2(DEPTH), pointer width (derived; not overridden)
AF_LVL, DEPTH-2, almost_full asserts when level >= AF_LVL
AE_LVL, 2, almost_empty asserts when level <= AE_LVL

Ports:
clk  input  1  clock, rising edge
sys_rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush
wr_en  input  1  write request
din  input  DW  write data
rd_en  input  1  read request
dout  output  DW  read data
rd_valid  output  1  dout carries newly read word
full  output  1  level == DEPTH
empty  output  1  level == 0
almost_full  output  1  level >= AF_LVL
almost_empty  output  1  level <= AE_LVL
level  output  AW+1  current occupancy, 0..DEPTH
ovf  output  1  sticky: write attempted while full and not accepted
udf  output  1  sticky: read attempted while empty

Behaviour:
- Reset (sys_rst high, async): wr_ptr=rd_ptr=0, level=0, dout=0, rd_valid=0, ovf=udf=0. Flags follow: empty=1, full=0, almost_empty=1, almost_full=(AF_LVL==0). Storage is not reset.
- Reset asserted mid-operation: all queued data is discarded immediately. Operation resumes on the first clk edge after deassertion.
- Accept rules, evaluated on current-cycle state:
  - wr_acc = wr_en & (~full | rd_acc)
  - rd_acc = rd_en & ~empty
  - Full with rd+wr: both accepted, level unchanged (pass-through).
  - Empty with rd+wr: write accepted, read rejected, udf set.
- Pointers increment on accept and wrap from DEPTH-1 to 0 (explicit compare, not natural overflow).
- Level update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- All flags are registered, or derived combinationally from registered level. No combinational path from wr_en/rd_en to any flag.
- Read latency 1: on rd_acc, the mem[rd_ptr] word appears on dout at the next edge and rd_valid=1 for one cycle. Otherwise rd_valid=0 and dout holds its last value (no zeroing).
- Write data is in memory at the edge of wr_acc and is readable from the following cycle.
- ovf sets on wr_en & ~wr_acc. udf sets on rd_en & empty. Both clear only on sys_rst or clr.
- clr has priority over rd/wr in the same cycle: pointers=0, level=0, rd_valid=0, ovf=udf=0, dout holds.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined (first-word-fall-through): dout = mem[rd_ptr] combinationally whenever ~empty; rd_valid = ~empty; rd_en acts as acknowledge/pop; read latency 0.
- Undefined: standard mode, read latency 1, as described in Behaviour.
- Accept rules, flags and level are identical in both modes.

Decomposition:
- Shared package/header ekf_fifo_pkg holds:
  - clog2 helper
  - default DW/DEPTH constants for the RSA datapath
  - level-width localparam formula
- One sub-module, fifo_ram_2p: DEPTH x DW storage, synchronous write, asynchronous read port. Lets the storage be swapped for a BRAM wrapper later.
- Pointer, level, flag and error logic stay in sync_fifo_param.

Test Plan:
All scenarios use DW=16, DEPTH=6, AF_LVL=4, AE_LVL=1, standard mode unless noted.
- Fill/drain: write 0x1001..0x1006 with no reads → full=1, level=6, almost_full from level 4. Then 6 reads → dout 0x1001..0x1006 in order, each with rd_valid one cycle after rd_en, and empty=1 at the end.
- Wrap-around: 4 writes, 4 reads, then 6 writes 0xA0..0xA5 and 6 reads → pointers wrap past 5 to 0 and data returns 0xA0..0xA5 intact.
- Simultaneous rd+wr at full: hold rd_en=wr_en=1 for 3 cycles with level=6 → level stays 6, ovf=0, output order preserved. Same test at empty → level goes to 1, udf=1, rd_valid=0.
- Errors and clr: write while full without read → ovf=1, data not stored. ovf stays set through 10 idle cycles; clr → ovf=0, level=0, empty=1. clr asserted with wr_en in the same cycle → nothing written.
- Async reset mid-burst: assert sys_rst between clock edges with level=3 → level, flags and rd_valid reset immediately without waiting for a clock edge. A write after deassertion reads back correctly.
- FWFT (SYNC_FIFO_FWFT_EN defined): write 0x55AA → dout=0x55AA and rd_valid=1 in the cycle after the write, with no rd_en. rd_en for 1 cycle → empty=1, rd_valid=0.

Source files
------------

// File: rtl/ekf_fifo_pkg.sv
// Shared constants and helpers for the RSA/EKF FIFO slice.
// Optional build macro used by sync_fifo_param: SYNC_FIFO_FWFT_EN.
package ekf_fifo_pkg;

  localparam int unsigned RSA_DW    = 16;
  localparam int unsigned RSA_DEPTH = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Occupancy counter needs one extra bit so it can hold the value DEPTH.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  localparam int unsigned RSA_LW = lvl_w(RSA_DEPTH);

endpackage

// File: rtl/fifo_ram_2p.sv
// DEPTH x DW storage: synchronous write port, asynchronous read port.
// Kept separate so it can be replaced by a BRAM wrapper.
module fifo_ram_2p #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with level, almost flags, flush and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is latency-1 reads.
module sync_fifo_param
  import ekf_fifo_pkg::*;
#(
  parameter int unsigned DW     = RSA_DW,
  parameter int unsigned DEPTH  = RSA_DEPTH,
  parameter int unsigned AW     = clog2(DEPTH),
  parameter int unsigned AF_LVL = DEPTH - 2,
  parameter int unsigned AE_LVL = 2
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf
);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   lvl_t;

  localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);
  localparam lvl_t LVL_FULL = lvl_t'(DEPTH);
  localparam lvl_t LVL_AF   = lvl_t'(AF_LVL);
  localparam lvl_t LVL_AE   = lvl_t'(AE_LVL);

  ptr_t          wr_ptr;
  ptr_t          rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic [DW-1:0] ram_rdata;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_LAST) ? '0 : ptr_t'(p + 1'b1);
  endfunction

  assign empty        = (level == '0);
  assign full         = (level == LVL_FULL);
  assign almost_full  = (level >= LVL_AF);
  assign almost_empty = (level <= LVL_AE);

  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  fifo_ram_2p #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~clr),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   level <= lvl_t'(level + 1'b1);
        2'b01:   level <= lvl_t'(level - 1'b1);
        default: level <= level;
      endcase
      if (wr_en & ~wr_acc) ovf <= 1'b1;
      if (rd_en & empty)   udf <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout     = ram_rdata;
  assign rd_valid = ~empty;
`else
  // dout holds its last word through idle cycles and flushes.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      dout     <= '0;
      rd_valid <= 1'b0;
    end else if (clr) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) dout <= ram_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (DW=16, DEPTH=6, AF_LVL=4, AE_LVL=1).
// Works in both the default and SYNC_FIFO_FWFT_EN builds.
module tb_sync_fifo_param;

  localparam int D = 6;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        clr = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] din = '0;
  logic        rd_en = 1'b0;
  logic [15:0] dout;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  level;
  logic        ovf;
  logic        udf;

  sync_fifo_param #(
    .DW     (16),
    .DEPTH  (6),
    .AF_LVL (4),
    .AE_LVL (1)
  ) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .clr          (clr),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .ovf          (ovf),
    .udf          (udf)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] mq[$];     // model contents
  logic [15:0] exp_q[$];  // words expected on dout
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  logic        m_rv  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int          sz;
    logic [15:0] e;
    sz = mq.size();
    chk("level", 32'(level), 32'(sz));
    chk("full", 32'(full), 32'(sz == D));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("almost_full", 32'(almost_full), 32'(sz >= 4));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 1));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("rd_valid", 32'(rd_valid), 32'(sz != 0));
    if (sz != 0) chk("dout", 32'(dout), 32'(mq[0]));
    exp_q.delete();
`else
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    if (m_rv) begin
      e = exp_q.pop_front();
      if (rd_valid) chk("dout", 32'(dout), 32'(e));
    end
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rv  = 1'b0;
  endtask

  task automatic step(input logic w, input logic r, input logic [15:0] d, input logic c);
    bit ra, wa;
    wr_en = w;
    rd_en = r;
    din   = d;
    clr   = c;
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      ra = r && (mq.size() != 0);
      wa = w && ((mq.size() != D) || ra);
      if (w && !wa) m_ovf = 1'b1;
      if (r && mq.size() == 0) m_udf = 1'b1;
      m_rv = ra;
      if (ra) exp_q.push_back(mq.pop_front());
      if (wa) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
    check_state();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_state();
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_dout", 32'(dout), 32'h0);
`endif
    @(negedge clk);
    sys_rst = 1'b0;

    // fill / drain
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'(16'h1001 + i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h0, 1'b0);

    // wrap-around
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h0B00 + i), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'(16'h00A0 + i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h0, 1'b0);

    // simultaneous rd+wr at full, then at empty
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'(16'h2000 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'(16'h3000 + i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'(16'h4000 + i), 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);

    // overflow, sticky through idle, drain, flush, flush beats write
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'(16'h5000 + i), 1'b0);
    step(1'b1, 1'b0, 16'hDEAD, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h6666, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b0);

    // async reset between edges with level 3
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'(16'h7000 + i), 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0);
    #2;
    sys_rst = 1'b1;
    #1;
    model_reset();
    check_state();
    @(negedge clk);
    sys_rst = 1'b0;
    step(1'b1, 1'b0, 16'hBEEF, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0);

    // single word: visible without rd_en in FWFT, then popped
    step(1'b1, 1'b0, 16'h55AA, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
